// File: rtl/gpr_wb_ctrl.sv
// Purpose : GPR write-back controller; merges ALU (src0, priority) and load (src1) results through an in-order FIFO onto the single register-file write port.
// Latency : result accepted at edge E is presented (we_=0) after edge E+1 and captured by the GPR at edge E+2.
// Backpr. : rdy is derived from the registered count only (a same-cycle pop is not credited); src1 yields to src0 when a single slot is free.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   flush              synchronous discard of all queued writes
//   src0_* / src1_*    valid/ready result inputs (addr, data)
//   we_, wr_addr, wr_data  registered GPR write port, we_ active-low
//   pend_mask          one bit per register with a queued or in-flight write
//   empty              nothing queued and no write being presented
//
// Build option: define GPR_WB_R0_DROP_EN to swallow writes to register 0
// (handshaken but never enqueued, pend_mask[0] held at 0).

module gpr_wb_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   src0_vld,
    output logic                   src0_rdy,
    input  logic [ADDR_W-1:0]      src0_addr,
    input  logic [DATA_W-1:0]      src0_data,
    input  logic                   src1_vld,
    output logic                   src1_rdy,
    input  logic [ADDR_W-1:0]      src1_addr,
    input  logic [DATA_W-1:0]      src1_data,
    output logic                   we_,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [(2**ADDR_W)-1:0] pend_mask,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;

    logic acc0, acc1;
    logic enq0, enq1;
    logic pop;
    logic [CNT_W-1:0] n_enq;
    logic [PTR_W-1:0] wr_ptr_1;
    logic [PTR_W-1:0] scan_idx;

    // Acceptance
    assign free     = CNT_W'(DEPTH) - count;
    assign src0_rdy = !flush && (free >= CNT_W'(1));
    assign src1_rdy = !flush && ((free >= CNT_W'(2)) ||
                                 ((free >= CNT_W'(1)) && !src0_vld));

    assign acc0 = src0_vld && src0_rdy;
    assign acc1 = src1_vld && src1_rdy;

`ifdef GPR_WB_R0_DROP_EN
    // r0 is hardwired to zero: complete the handshake but never queue it.
    assign enq0 = acc0 && (src0_addr != '0);
    assign enq1 = acc1 && (src1_addr != '0);
`else
    assign enq0 = acc0;
    assign enq1 = acc1;
`endif

    assign pop      = (count != '0);
    assign n_enq    = {{(CNT_W-1){1'b0}}, enq0} + {{(CNT_W-1){1'b0}}, enq1};
    assign wr_ptr_1 = wr_ptr + PTR_W'(1);

    // Entry storage; only entries below count are ever observed, so no reset.
    // When both sources enqueue, src0 takes the lower slot to keep program order.
    always_ff @(posedge clk) begin
        if (enq0) begin
            mem_addr[wr_ptr] <= src0_addr;
            mem_data[wr_ptr] <= src0_data;
        end
        if (enq1) begin
            mem_addr[enq0 ? wr_ptr_1 : wr_ptr] <= src1_addr;
            mem_data[enq0 ? wr_ptr_1 : wr_ptr] <= src1_data;
        end
    end

    // Pointers, count and the registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            we_     <= 1'b1;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (flush) begin
            // The write already on the port completes this edge; nothing follows it.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            we_    <= 1'b1;
        end else begin
            if (pop) begin
                wr_addr <= mem_addr[rd_ptr];
                wr_data <= mem_data[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
                we_     <= 1'b0;
            end else begin
                we_ <= 1'b1;
            end
            wr_ptr <= wr_ptr + PTR_W'(n_enq);
            count  <= count + n_enq - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    // Pending-write mask: every live FIFO entry plus the write on the port.
    always_comb begin
        pend_mask = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                pend_mask[mem_addr[scan_idx]] = 1'b1;
            end
        end
        if (!we_) begin
            pend_mask[wr_addr] = 1'b1;
        end
`ifdef GPR_WB_R0_DROP_EN
        pend_mask[0] = 1'b0;
`endif
    end

    assign empty = (count == '0) && we_;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Purpose : self-checking bench for gpr_wb_ctrl against a queue-based reference model.
// Latency : model pops the queue head onto the write port at every edge it is non-empty.
// Backpr. : expected rdy computed from the model queue depth before each edge.

module tb_gpr_wb_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int NREG   = 2**ADDR_W;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              src0_vld, src1_vld;
    logic              src0_rdy, src1_rdy;
    logic [ADDR_W-1:0] src0_addr, src1_addr;
    logic [DATA_W-1:0] src0_data, src1_data;
    logic              we_;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   pend_mask;
    logic              empty;

    gpr_wb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src0_vld  (src0_vld),
        .src0_rdy  (src0_rdy),
        .src0_addr (src0_addr),
        .src0_data (src0_data),
        .src1_vld  (src1_vld),
        .src1_rdy  (src1_rdy),
        .src1_addr (src1_addr),
        .src1_data (src1_data),
        .we_       (we_),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_mask (pend_mask),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pending writes in accept order, plus the write on the port.
    logic [ADDR_W+DATA_W-1:0] q[$];
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    // Register file as seen through the DUT's write port.
    logic [DATA_W-1:0] dut_gpr [NREG];
    int                n_r0_wr;

    // DUT values sampled at the last check point, for directed checks.
    logic s_rdy0, s_rdy1, s_we, s_empty;
    logic [NREG-1:0] s_pend;

    task automatic model_reset();
        q.delete();
        exp_we   = 1'b1;
        exp_addr = '0;
        exp_data = '0;
    endtask

    function automatic bit drop_r0(input logic [ADDR_W-1:0] a);
`ifdef GPR_WB_R0_DROP_EN
        return (a == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic f,
                        input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        int free;
        logic e_rdy0, e_rdy1;
        logic [NREG-1:0] e_pend;
        @(negedge clk);
        flush = f;
        src0_vld = v0; src0_addr = a0; src0_data = d0;
        src1_vld = v1; src1_addr = a1; src1_data = d1;
        #1;
        free   = DEPTH - q.size();
        e_rdy0 = !f && (free >= 1);
        e_rdy1 = !f && ((free >= 2) || (free >= 1 && !v0));
        e_pend = '0;
        foreach (q[i]) e_pend[q[i][ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
        if (!exp_we) e_pend[exp_addr] = 1'b1;
        chk("src0_rdy", src0_rdy, e_rdy0);
        chk("src1_rdy", src1_rdy, e_rdy1);
        chk("we_", we_, exp_we);
        if (!exp_we) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, exp_data);
        end
        chk("pend_mask", pend_mask, e_pend);
        chk("empty", empty, (q.size() == 0) && exp_we);
        s_rdy0 = src0_rdy; s_rdy1 = src1_rdy; s_we = we_; s_empty = empty; s_pend = pend_mask;
        if (!we_) begin
            dut_gpr[wr_addr] = wr_data;
            if (wr_addr == 0) n_r0_wr++;
        end
        @(posedge clk);
        // Model update: head drains from the pre-edge contents, then new results append.
        if (f) begin
            q.delete();
            exp_we = 1'b1;
        end else begin
            if (q.size() > 0) begin
                {exp_addr, exp_data} = q.pop_front();
                exp_we = 1'b0;
            end else begin
                exp_we = 1'b1;
            end
            if (v0 && e_rdy0 && !drop_r0(a0)) q.push_back({a0, d0});
            if (v1 && e_rdy1 && !drop_r0(a1)) q.push_back({a1, d1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        src0_vld = 1'b0; src0_addr = '0; src0_data = '0;
        src1_vld = 1'b0; src1_addr = '0; src1_data = '0;
        n_r0_wr = 0;
        for (int r = 0; r < NREG; r++) dut_gpr[r] = '0;
        model_reset();
        #12;
        chk("rst_we_", we_, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_pend", pend_mask, '0);
        chk("rst_wr_addr", wr_addr, '0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Single write to r5
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0);
        #1;
        chk("single_pend5_e", pend_mask[5], 1'b1);
        chk("single_we_e", we_, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("single_we_e1", we_, 1'b0);
        chk("single_addr_e1", wr_addr, 5'd5);
        chk("single_data_e1", wr_data, 32'h1234_5678);
        chk("single_pend5_e1", pend_mask[5], 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("single_we_e2", we_, 1'b1);
        chk("single_pend5_e2", pend_mask[5], 1'b0);
        chk("single_gpr5", dut_gpr[5], 32'h1234_5678);

        // Dual accept to the same register: src0 first, src1 wins
        step(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        chk("dual_rdy1", s_rdy1, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("dual_gpr7_first", dut_gpr[7], 32'hA);
        idle(2);
        chk("dual_gpr7_last", dut_gpr[7], 32'hB);

        // Fill to three entries, then both valid: only src0 fits
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        step(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        chk("c3_rdy0", s_rdy0, 1'b1);
        chk("c3_rdy1", s_rdy1, 1'b0);

        // Flush with entries queued and a write on the port
        step(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        chk("flush_rdy0", s_rdy0, 1'b0);
        chk("flush_inflight", s_we, 1'b0);
        #1;
        chk("flush_we_", we_, 1'b1);
        chk("flush_pend", pend_mask, '0);
        chk("flush_empty", empty, 1'b1);
        idle(2);

        // Reset mid-operation with three entries queued
        step(1'b0, 1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
        step(1'b0, 1'b1, 5'd12, 32'h3, 1'b1, 5'd13, 32'h4);
        src0_vld = 1'b0; src1_vld = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we_", we_, 1'b1);
        chk("mid_rst_pend", pend_mask, '0);
        chk("mid_rst_empty", empty, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 5'd3, 32'h5, 1'b0, '0, '0);
        chk("post_rst_rdy0", s_rdy0, 1'b1);
        idle(3);

        // Write to r0
        n_r0_wr = 0;
        step(1'b0, 1'b1, 5'd0, 32'hFF, 1'b0, '0, '0);
        idle(3);
`ifdef GPR_WB_R0_DROP_EN
        chk("r0_writes", n_r0_wr, 0);
`else
        chk("r0_writes", n_r0_wr, 1);
`endif

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), $urandom(),
                 ($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), $urandom());
        end
        idle(DEPTH + 2);
        chk("final_empty", s_empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Write-back controller that owns the single GPR write port (we_, wr_addr, wr_data).
- Accepts results from two producers:
  - src0: EX/ALU, higher priority.
  - src1: MEM/load.
- Results are buffered in an in-order FIFO and drained to the register file at one write per cycle from registered outputs.
- Exports a pending-write mask so decode can detect RAW hazards on registers not yet written.

Parameters:
- ADDR_W, 5, GPR address width (matches GprAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous discard of all queued writes, active-high
- src0_vld  in  1  ALU result valid
- src0_rdy  out  1  ALU result accepted when vld&rdy
- src0_addr  in  ADDR_W  destination register
- src0_data  in  DATA_W  result
- src1_vld  in  1  load result valid
- src1_rdy  out  1  load result accepted when vld&rdy
- src1_addr  in  ADDR_W  destination register
- src1_data  in  DATA_W  result
- we_  out  1  GPR write enable, active-low, registered
- wr_addr  out  ADDR_W  GPR write address, registered
- wr_data  out  DATA_W  GPR write data, registered
- pend_mask  out  2**ADDR_W  bit r set while any queued or in-flight write targets r
- empty  out  1  FIFO empty and we_ high

Behaviour:
- Reset (rst low, async):
  - FIFO pointers and count cleared.
  - we_=1; wr_addr=0; wr_data=0.
  - pend_mask=0; empty=1.
- Acceptance, combinational on the registered count; the same-cycle drain is not credited:
  - free = DEPTH - count.
  - src0_rdy = !flush & (free>=1).
  - src1_rdy = !flush & ((free>=2) | (free>=1 & !src0_vld)).
- Enqueue order when both are accepted in the same cycle: src0 entry first, then src1.
- Drain, every rising edge:
  - If FIFO non-empty: head pops into wr_addr/wr_data, and we_=0 for the next cycle.
  - Otherwise we_=1, and wr_addr/wr_data hold their values.
- Latency: a result accepted at edge E drives we_=0 in the cycle after edge E+1, and the GPR captures it at edge E+2.
- Throughput is 1 write/cycle. Sustained dual-source input stalls src1.
- Enqueue and pop in the same edge are allowed. The count update is +accepted-popped. Full with a simultaneous pop still shows rdy low that cycle (conservative).
- Ordering: strict FIFO. Two writes to the same register always reach the GPR in accept order, so the last value wins.
- Pointers wrap modulo DEPTH. count occupies ADDR_W-independent clog2(DEPTH)+1 bits.
- flush high at an edge:
  - FIFO emptied and pointers reset.
  - No acceptance that cycle.
  - we_=1 next cycle; the write already presented on the output this cycle still completes.
- pend_mask = OR over valid FIFO entries of one-hot(addr), OR one-hot(wr_addr) when we_=0. Combinational from registered state.
- empty = (count==0) & we_.

Optional Feature:
- Macro: GPR_WB_R0_DROP_EN.
- Defined: results with addr==0 are handshaken (rdy per the normal rule) but not enqueued. They never assert we_, and pend_mask bit 0 is always 0.
- Undefined: addr 0 is handled like any other register.

Test Plan:
- Reset mid-operation: 3 entries queued, rst low -> same cycle we_=1, pend_mask=0, empty=1. After release, src0_rdy=1.
- Single write: src0 addr=5 data=0x1234_5678 at edge E -> we_=0, wr_addr=5, wr_data=0x12345678 in the cycle after E+1. pend_mask[5]=1 from after E until after E+2.
- Dual accept, same register: src0 (7, 0xA), src1 (7, 0xB) both accepted at edge E -> GPR writes 0xA then 0xB on consecutive cycles. Final gpr[7]=0xB.
- Full/backpressure, DEPTH=4:
  - Hold src0_vld with no drain stall -> src0_rdy drops when count=4.
  - With count=3, src0 and src1 both valid -> src0_rdy=1, src1_rdy=0.
- Flush: 4 entries queued, flush pulse -> at most the one in-flight write completes, then we_=1 and pend_mask=0.
- R0 handling: src0 addr=0 data=0xFF -> with GPR_WB_R0_DROP_EN, we_ stays 1. Without it, one write to addr 0 occurs.
